per_uart_tx: RTL and testbench
==============================

// Module: per_uart_tx
// PURPOSE
// - Peripheral-bus responder: memory-mapped UART transmitter on the openMSP430 per_* bus.
// - Core writes bytes into a small TX FIFO; block serialises them 8N1, LSB first, on txd.
// - Sits beside the LED register in the peripheral space; per_dout is ORed with other peripherals.
// PARAMETERS
// - BASE_ADDR   8'h08   word address of register 0; block decodes BASE_ADDR..BASE_ADDR+3
// - FIFO_DEPTH  4       TX FIFO entries (power of 2, >=2)
// - BAUD_RST    16'd433 reset value of BAUD (bit time = BAUD+1 clk cycles)
// PORTS
// - clk       in   1   system clock (same as dco_clk)
// - rstbar    in   1   asynchronous active-low reset
// - per_en    in   1   peripheral enable (high active)
// - per_we    in   2   byte write enables: [0]=bits 7:0, [1]=bits 15:8
// - per_addr  in   8   peripheral word address
// - per_din   in   16  write data from core
// - per_dout  out  16  read data; 16'h0 when not selected as a read
// - txd       out  1   serial output, idle high
// - tx_irq    out  1   level interrupt: CTRL.IE & FIFO empty & ~busy
// BEHAVIOUR
// - Registers (word offset): 0 CTRL {14'b0, IE, EN}; 1 STATUS {12'b0, OVF, EMPTY, FULL, BUSY};
//   2 BAUD[15:0]; 3 TXDATA (write-only, reads 16'h0).
// - sel = per_en & (per_addr[7:2]==BASE_ADDR[7:2]); rd = sel & (per_we==2'b00); wr byte k = sel & per_we[k].
// - Reads combinational, same cycle as per_en; per_dout = 0 whenever rd is low.
// - Writes take effect on clk edge. CTRL/BAUD honour byte enables. STATUS: write 1 to bit3 clears OVF; other bits RO.
// - TXDATA write with per_we[0]: push per_din[7:0]; per_we[1] alone ignored.
// - Push when FULL: dropped, OVF set (sticky). Push when FULL with same-cycle pop: accepted, no OVF.
// - FSM IDLE->START->DATA->STOP->IDLE. IDLE: if EN & ~EMPTY, pop head into shift reg, latch BAUD, go START.
// - txd: START=0, DATA=shift[0] with 8 bits LSB first, STOP=1; each state bit lasts latched BAUD+1 cycles.
// - Pop cycle t -> txd falls at t+1; frame = 10*(BAUD+1) cycles; back-to-back frames with no idle gap
//   (STOP last cycle transitions directly to START if EN & ~EMPTY).
// - BAUD write mid-frame: applies from next frame. BAUD=0 -> 1 cycle/bit.
// - EN cleared mid-frame: current frame completes; no new frame starts; FIFO contents kept.
// - BUSY = (state != IDLE). Push to empty FIFO while idle & EN: popped next cycle.
// - Counters: 16-bit baud counter, 3-bit bit index, FIFO pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
// - Reset (async, any time incl. mid-frame): txd=1, state IDLE, FIFO empty, OVF=0, CTRL=0,
//   BAUD=BAUD_RST, tx_irq=0, per_dout=0.
// STRUCTURE
// - Package per_uart_pkg: register offsets (REG_CTRL..REG_TXDATA), STATUS/CTRL bit indices, FSM state enum.
// - Sub-module per_sync_fifo (WIDTH=8, DEPTH param): push/pop/full/empty/count, pop-on-full-push rule.
// - Top: address decode + register file + FSM/baud counter/shift register.
// TESTING
// - Reset: rstbar low -> txd=1, STATUS reads 16'h0004, BAUD reads 433, tx_irq=0.
// - BAUD=3, CTRL=1, write TXDATA=8'hA5 -> txd 0,1,0,1,0,0,1,0,1,1 each 4 cycles, falling at push+2.
// - EN=1, write 5 bytes back-to-back at BAUD=9 -> first popped, 4 buffered, no OVF; 6th write while full -> OVF=1, byte lost.
// - Write STATUS=16'h0008 -> OVF cleared; reads of unmapped BASE_ADDR+4 and non-selected cycles return 16'h0.
// - CTRL=3 with empty FIFO -> tx_irq=1; push byte -> tx_irq=0 until STOP ends and FIFO empty.
// - Pull rstbar low mid-DATA -> txd=1 immediately, FIFO empty; after release, no residual frame emitted.

Source files
------------

// File: rtl/per_uart_pkg.sv
// -----------------------------------------------------------------------------
// per_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - word offsets of the four registers inside the decoded window
//   - bit positions of the CTRL and STATUS fields
//   - transmitter FSM state encoding
// -----------------------------------------------------------------------------
package per_uart_pkg;

   // Register word offsets (per_addr[1:0])
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;
   localparam logic [1:0] REG_TXDATA = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;

   // STATUS bit positions
   localparam int STATUS_BUSY  = 0;
   localparam int STATUS_FULL  = 1;
   localparam int STATUS_EMPTY = 2;
   localparam int STATUS_OVF   = 3;

   // Serial frame sequencer: 8N1, one state per frame section
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage : per_uart_pkg

// File: rtl/per_sync_fifo.sv
// -----------------------------------------------------------------------------
// per_sync_fifo
// Single-clock FIFO with first-word fall-through read port (dout always shows
// the head entry). A push while full is accepted only when a pop happens in
// the same cycle; otherwise it is silently dropped (the parent flags overflow).
//
// Ports
//   clk     in   1                 clock
//   rstbar  in   1                 asynchronous active-low reset (empties FIFO)
//   push    in   1                 write din at the tail
//   din     in   WIDTH             write data
//   pop     in   1                 remove head entry (ignored when empty)
//   dout    out  WIDTH             head entry
//   full    out  1                 count == DEPTH
//   empty   out  1                 count == 0
//   count   out  clog2(DEPTH+1)    number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module per_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4      // power of 2, >= 2
) (
   input  logic                       clk,
   input  logic                       rstbar,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign count   = cnt;
   assign dout    = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a push on a full FIFO is still
   // accepted when it coincides with a pop.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: storage has no reset; only pointers/count are reset, and an entry is
   // never read before it has been written, so resetting the array would only
   // add reset fan-out and block RAM inference.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits wide, so they wrap naturally.
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule : per_sync_fifo

// File: rtl/per_uart_tx.sv
// -----------------------------------------------------------------------------
// per_uart_tx
// Memory-mapped UART transmitter on the openMSP430 peripheral bus. The core
// writes bytes into a small TX FIFO; the block serialises them as 8N1 frames,
// LSB first, on txd. per_dout is zero unless this block is being read, so it
// can be ORed with the other peripherals' read data.
//
// Register map (word offset from BASE_ADDR)
//   0 CTRL    {14'b0, IE, EN}                    R/W
//   1 STATUS  {12'b0, OVF, EMPTY, FULL, BUSY}    write 1 to OVF clears it
//   2 BAUD    bit time = BAUD+1 clk cycles       R/W
//   3 TXDATA  write [7:0] pushes a byte          reads 0
//
// Ports
//   clk       in   1    system clock
//   rstbar    in   1    asynchronous active-low reset
//   per_en    in   1    peripheral access strobe
//   per_we    in   2    byte write enables ([0]=7:0, [1]=15:8); 0 = read
//   per_addr  in   8    peripheral word address
//   per_din   in   16   write data
//   per_dout  out  16   read data, 0 when not read
//   txd       out  1    serial output, idle high
//   tx_irq    out  1    level interrupt: IE & FIFO empty & not busy
// -----------------------------------------------------------------------------
module per_uart_tx
   import per_uart_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR  = 8'h08,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] BAUD_RST   = 16'd433
) (
   input  logic        clk,
   input  logic        rstbar,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   input  logic [7:0]  per_addr,
   input  logic [15:0] per_din,
   output logic [15:0] per_dout,
   output logic        txd,
   output logic        tx_irq
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   // ---------------------------------------------------------------- decode
   logic       sel;
   logic       rd;
   logic       wr_lo;
   logic       wr_hi;
   logic [1:0] reg_off;

   assign sel     = per_en & (per_addr[7:2] == BASE_ADDR[7:2]);
   assign reg_off = per_addr[1:0];
   assign rd      = sel & (per_we == 2'b00);
   assign wr_lo   = sel & per_we[0];
   assign wr_hi   = sel & per_we[1];

   // ------------------------------------------------------------ registers
   logic        ctrl_en;
   logic        ctrl_ie;
   logic [15:0] baud;
   logic        ovf;
   logic        ovf_set;
   logic        ovf_clr;

   // ------------------------------------------------------------ TX FIFO
   logic             tx_push;
   logic             fifo_pop;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Only the low byte lane carries TX data; a high-lane-only write is ignored.
   assign tx_push = wr_lo & (reg_off == REG_TXDATA);

   // A push is lost only when the FIFO is full and nothing leaves this cycle.
   assign ovf_set = tx_push & (fifo_count == CNT_W'(FIFO_DEPTH)) & ~fifo_pop;
   assign ovf_clr = wr_lo & (reg_off == REG_STATUS) & per_din[STATUS_OVF];

   per_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rstbar (rstbar),
      .push   (tx_push),
      .din    (per_din[7:0]),
      .pop    (fifo_pop),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) begin
         ctrl_en <= 1'b0;
         ctrl_ie <= 1'b0;
         baud    <= BAUD_RST;
         ovf     <= 1'b0;
      end else begin
         if (wr_lo && (reg_off == REG_CTRL)) begin
            ctrl_en <= per_din[CTRL_EN];
            ctrl_ie <= per_din[CTRL_IE];
         end
         if (wr_lo && (reg_off == REG_BAUD)) baud[7:0]  <= per_din[7:0];
         if (wr_hi && (reg_off == REG_BAUD)) baud[15:8] <= per_din[15:8];
         // A fresh overflow wins over a simultaneous clear so it is never missed.
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   // ---------------------------------------------------------- serialiser
   tx_state_e   state;
   tx_state_e   state_nxt;
   logic [15:0] baud_cnt;
   logic [15:0] baud_lat;   // bit time frozen for the whole frame
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        bit_end;
   logic        frame_rdy;
   logic        busy;

   assign bit_end   = (baud_cnt == baud_lat);
   assign frame_rdy = ctrl_en & ~fifo_empty;

   // State register
   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) state <= TX_IDLE;
      else         state <= state_nxt;
   end

   // Next state; the pop is the IDLE->START / STOP->START transition itself,
   // so back-to-back frames leave no idle cycle between stop and start.
   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         TX_IDLE: begin
            if (frame_rdy) begin
               fifo_pop  = 1'b1;
               state_nxt = TX_START;
            end
         end
         TX_START: begin
            if (bit_end) state_nxt = TX_DATA;
         end
         TX_DATA: begin
            if (bit_end && (bit_idx == 3'd7)) state_nxt = TX_STOP;
         end
         TX_STOP: begin
            if (bit_end) begin
               if (frame_rdy) begin
                  fifo_pop  = 1'b1;
                  state_nxt = TX_START;
               end else begin
                  state_nxt = TX_IDLE;
               end
            end
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      txd  = 1'b1;
      busy = (state != TX_IDLE);
      case (state)
         TX_START: txd = 1'b0;
         TX_DATA:  txd = shift[0];
         default:  txd = 1'b1;
      endcase
   end

   // Bit timing and shift register
   always_ff @(posedge clk or negedge rstbar) begin
      if (!rstbar) begin
         baud_cnt <= '0;
         baud_lat <= BAUD_RST;
         bit_idx  <= '0;
         shift    <= 8'hFF;
      end else if (fifo_pop) begin
         shift    <= fifo_dout;
         baud_lat <= baud;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else if (state != TX_IDLE) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (state == TX_DATA) begin
               shift   <= {1'b1, shift[7:1]};
               bit_idx <= bit_idx + 3'd1;   // wraps to 0 after bit 7
            end
         end else begin
            baud_cnt <= baud_cnt + 16'd1;
         end
      end
   end

   assign tx_irq = ctrl_ie & fifo_empty & ~busy;

   // ------------------------------------------------------------ read mux
   // NOTE: every output of this block is given a default before the case, so
   // no path leaves a value held and no latch is inferred.
   always_comb begin
      per_dout = 16'h0000;
      if (rd) begin
         case (reg_off)
            REG_CTRL: begin
               per_dout[CTRL_EN] = ctrl_en;
               per_dout[CTRL_IE] = ctrl_ie;
            end
            REG_STATUS: begin
               per_dout[STATUS_BUSY]  = busy;
               per_dout[STATUS_FULL]  = fifo_full;
               per_dout[STATUS_EMPTY] = fifo_empty;
               per_dout[STATUS_OVF]   = ovf;
            end
            REG_BAUD: per_dout = baud;
            default:  per_dout = 16'h0000;   // TXDATA is write-only
         endcase
      end
   end

endmodule : per_uart_tx

// File: tb/tb_per_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_per_uart_tx
// Directed bench for per_uart_tx: register access, byte enables, serial frame
// timing, FIFO overflow, interrupt timing and asynchronous reset mid-frame.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_per_uart_tx;

   localparam logic [7:0] BASE   = 8'h08;
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_BAUD   = 2'd2;
   localparam logic [1:0] OFF_TXDATA = 2'd3;

   logic        clk = 1'b0;
   logic        rstbar;
   logic        per_en;
   logic [1:0]  per_we;
   logic [7:0]  per_addr;
   logic [15:0] per_din;
   logic [15:0] per_dout;
   logic        txd;
   logic        tx_irq;

   int n_checks = 0;
   int n_errors = 0;

   per_uart_tx #(
      .BASE_ADDR  (8'h08),
      .FIFO_DEPTH (4),
      .BAUD_RST   (16'd433)
   ) dut (
      .clk      (clk),
      .rstbar   (rstbar),
      .per_en   (per_en),
      .per_we   (per_we),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_dout (per_dout),
      .txd      (txd),
      .tx_irq   (tx_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [15:0] data, input logic [1:0] we);
      per_en   = 1'b1;
      per_we   = we;
      per_addr = BASE | {6'b0, off};
      per_din  = data;
      @(posedge clk);
      #1;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_din  = 16'h0000;
   endtask

   task automatic check_rd(input string tag, input logic [7:0] addr, input logic [15:0] exp);
      per_en   = 1'b1;
      per_we   = 2'b00;
      per_addr = addr;
      #1;
      check(tag, per_dout, exp);
      per_en   = 1'b0;
   endtask

   // Receives one frame at BAUD=9 (10 cycles/bit): waits up to 'bound' cycles
   // for a falling edge, then samples the middle of every bit.
   task automatic recv(input int bound, output logic [7:0] data, output logic found,
                       output logic framing_ok);
      logic prev;
      prev       = txd;
      found      = 1'b0;
      framing_ok = 1'b0;
      data       = 8'h00;
      for (int k = 0; k < bound; k++) begin
         @(posedge clk);
         #1;
         if (prev && !txd) begin
            found = 1'b1;
            break;
         end
         prev = txd;
      end
      if (found) begin
         wait_cycles(4);
         framing_ok = ~txd;
         for (int b = 0; b < 8; b++) begin
            wait_cycles(10);
            data[b] = txd;
         end
         wait_cycles(10);
         framing_ok = framing_ok & txd;
      end
   endtask

   // Cycles from the sample after a push until tx_irq first reads high.
   task automatic measure_irq(output int first);
      first = 0;
      for (int k = 1; k <= 60; k++) begin
         wait_cycles(1);
         if (first == 0 && tx_irq) first = k;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  frame;
      logic [7:0]  bytes [6];
      logic [7:0]  got;
      logic        found;
      logic        fr_ok;
      int          first;
      int          lows;

      rstbar   = 1'b0;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = 8'h00;
      per_din  = 16'h0000;

      // ---------------- reset state
      #3;
      check("rst_txd", txd, 1'b1);
      check("rst_irq", tx_irq, 1'b0);
      check_rd("rst_status_in_reset", BASE | 8'd1, 16'h0004);
      wait_cycles(2);
      rstbar = 1'b1;
      wait_cycles(1);
      check_rd("rst_status", BASE | 8'd1, 16'h0004);
      check_rd("rst_baud", BASE | 8'd2, 16'd433);
      check_rd("rst_ctrl", BASE | 8'd0, 16'h0000);
      check_rd("txdata_reads_zero", BASE | 8'd3, 16'h0000);

      // ---------------- byte enables
      bus_wr(OFF_BAUD, 16'hABCD, 2'b01);
      check_rd("baud_lo_byte", BASE | 8'd2, 16'h01CD);
      bus_wr(OFF_BAUD, 16'h1200, 2'b10);
      check_rd("baud_hi_byte", BASE | 8'd2, 16'h12CD);
      bus_wr(OFF_TXDATA, 16'h5500, 2'b10);
      check_rd("txdata_hi_ignored", BASE | 8'd1, 16'h0004);

      // ---------------- single frame 0xA5 at BAUD=3
      bus_wr(OFF_BAUD, 16'd3, 2'b11);
      bus_wr(OFF_CTRL, 16'd1, 2'b11);
      bus_wr(OFF_TXDATA, 16'h00A5, 2'b01);
      check("a5_idle_before_start", txd, 1'b1);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            wait_cycles(1);
            check($sformatf("a5_bit%0d_c%0d", i, j), txd, frame[i]);
         end
      end
      wait_cycles(1);
      check_rd("a5_done_status", BASE | 8'd1, 16'h0004);

      // ---------------- fill FIFO at BAUD=9, overflow, clear
      bytes[0] = 8'h00; bytes[1] = 8'h3C; bytes[2] = 8'h81;
      bytes[3] = 8'h5A; bytes[4] = 8'hF0; bytes[5] = 8'h66;
      bus_wr(OFF_BAUD, 16'd9, 2'b11);
      for (int i = 0; i < 5; i++) bus_wr(OFF_TXDATA, {8'h00, bytes[i]}, 2'b01);
      check_rd("full_no_ovf", BASE | 8'd1, 16'h0003);
      bus_wr(OFF_TXDATA, {8'h00, bytes[5]}, 2'b01);
      check_rd("ovf_set", BASE | 8'd1, 16'h000B);
      bus_wr(OFF_STATUS, 16'h0008, 2'b01);
      check_rd("ovf_cleared", BASE | 8'd1, 16'h0003);
      check_rd("unmapped_read", BASE + 8'd4, 16'h0000);
      check_rd("below_base_read", 8'h04, 16'h0000);
      per_addr = BASE | 8'd2;
      per_en   = 1'b0;
      #1;
      check("not_selected_read", per_dout, 16'h0000);

      for (int i = 1; i < 5; i++) begin
         recv(400, got, found, fr_ok);
         check($sformatf("rx%0d_found", i), found, 1'b1);
         check($sformatf("rx%0d_byte", i), got, bytes[i]);
         check($sformatf("rx%0d_framing", i), fr_ok, 1'b1);
      end
      recv(300, got, found, fr_ok);
      check("lost_byte_not_sent", found, 1'b0);
      check_rd("drained_status", BASE | 8'd1, 16'h0004);

      // ---------------- interrupt timing
      bus_wr(OFF_BAUD, 16'd1, 2'b11);
      bus_wr(OFF_CTRL, 16'd3, 2'b11);
      check("irq_idle_empty", tx_irq, 1'b1);
      bus_wr(OFF_TXDATA, 16'h0055, 2'b01);
      check("irq_low_after_push", tx_irq, 1'b0);
      measure_irq(first);
      check("irq_return_baud1", first, 21);
      bus_wr(OFF_BAUD, 16'd0, 2'b11);
      bus_wr(OFF_TXDATA, 16'h00C3, 2'b01);
      measure_irq(first);
      check("irq_return_baud0", first, 11);

      // ---------------- reset in the middle of DATA
      bus_wr(OFF_BAUD, 16'd3, 2'b11);
      bus_wr(OFF_TXDATA, 16'h0000, 2'b01);
      bus_wr(OFF_TXDATA, 16'h0000, 2'b01);
      wait_cycles(8);
      check("mid_data_low", txd, 1'b0);
      check_rd("mid_data_status", BASE | 8'd1, 16'h0001);
      rstbar = 1'b0;
      #1;
      check("async_rst_txd", txd, 1'b1);
      check("async_rst_irq", tx_irq, 1'b0);
      check_rd("async_rst_status", BASE | 8'd1, 16'h0004);
      check_rd("async_rst_baud", BASE | 8'd2, 16'd433);
      wait_cycles(1);
      rstbar = 1'b1;
      lows = 0;
      for (int k = 0; k < 100; k++) begin
         wait_cycles(1);
         if (!txd) lows++;
      end
      check("no_residual_frame", lows, 0);
      check_rd("post_rst_ctrl", BASE | 8'd0, 16'h0000);
      check_rd("post_rst_status", BASE | 8'd1, 16'h0004);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_per_uart_tx
